// File: rtl/sdrx_pkg.sv
// Shared types and helpers for the SD data-block receiver.
// - state_e          : receiver FSM states
// - W1/W4/W8         : lane-width encodings
// - CRC_POLY/CRC_LEN : per-lane CRC16 parameters
// - lane_mask/edges_per_word/shift_word : width-dependent decode helpers
package sdrx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StData,
    StCrc,
    StStop,
    StHalt
  } state_e;

  localparam logic [1:0]  W1       = 2'b00;
  localparam logic [1:0]  W4       = 2'b01;
  localparam logic [1:0]  W8       = 2'b10;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam int unsigned CRC_LEN  = 16;

  // Width decode: bit0 set means 4 lanes (so 2'b11 is also 4 lanes), else bit1 means 8.
  function automatic logic [7:0] lane_mask(input logic [1:0] width);
    if (width == W1)   return 8'h01;
    else if (width[0]) return 8'h0F;
    else               return 8'hFF;
  endfunction

  function automatic logic [5:0] edges_per_word(input logic [1:0] width);
    if (width == W1)   return 6'd32;
    else if (width[0]) return 6'd8;
    else               return 6'd4;
  endfunction

  // Shift the active lanes into the word, highest lane as MSB of each slice.
  function automatic logic [31:0] shift_word(input logic [31:0] word, input logic [1:0] width,
                                             input logic [7:0] dat);
    if (width == W1)   return {word[30:0], dat[0]};
    else if (width[0]) return {word[27:0], dat[3:0]};
    else               return {word[23:0], dat};
  endfunction

endpackage

// File: rtl/sdrx_crc16.sv
// One-lane bit-serial CRC16 (init 0, MSB-first).
// Ports: sd_clk/rst_n clock and async active-low reset; i_clr zeroes the
// register; i_step folds i_bit into the CRC; i_shift shifts left by one
// (used while comparing the transmitted CRC); o_msb is the current CRC MSB.
// Priority: clear, then step, then shift.
module sdrx_crc16
  import sdrx_pkg::*;
(
  input  logic sd_clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_step,
  input  logic i_shift,
  input  logic i_bit,
  output logic o_msb
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (i_clr) begin
      crc_d = '0;
    end else if (i_step) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((i_bit ^ crc_q[15]) ? CRC_POLY : 16'h0000);
    end else if (i_shift) begin
      crc_d = {crc_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign o_msb = crc_q[15];

endmodule

// File: rtl/sdrx_frame.sv
// SD host-side data-block receiver.
// Samples 1/4/8-lane SDR data on rising sd_clk, detects the start bit,
// assembles MSB-first 32-bit words, checks per-lane CRC16 and the stop bit.
// Ports:
//   sd_clk, rst_n      : clock, async active-low reset
//   i_en               : arm; low aborts any transfer
//   i_width, i_len     : lane width, block length in bytes (multiple of 4)
//   i_dat              : data lanes at the pins
//   o_valid/o_data/o_last : word stream (valid-only, no backpressure)
//   o_done/o_crcerr/o_frmerr : block-end pulse and status
//   o_timeout          : no start bit within 2^LGTIMEOUT-1 cycles
//   o_busy             : not in IDLE or HALT
// All outputs are registered.
module sdrx_frame
  import sdrx_pkg::*;
#(
  parameter int unsigned LGTIMEOUT = 16
) (
  input  logic        sd_clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [1:0]  i_width,
  input  logic [11:0] i_len,
  input  logic [7:0]  i_dat,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_done,
  output logic [7:0]  o_crcerr,
  output logic        o_frmerr,
  output logic        o_timeout,
  output logic        o_busy
);

  state_e               state_q, state_d;
  logic [9:0]           wcnt_q, wcnt_d;
  logic [5:0]           bcnt_q, bcnt_d;
  logic [LGTIMEOUT-1:0] tcnt_q, tcnt_d;
  logic [1:0]           width_q, width_d;
  logic [31:0]          word_q, word_d;
  logic [7:0]           acc_q, acc_d;
  logic                 valid_q, valid_d;
  logic [31:0]          data_q, data_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic [7:0]           crcerr_q, crcerr_d;
  logic                 frmerr_q, frmerr_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;

  logic                 enter_ws;
  logic [7:0]           mask;
  logic [7:0]           crc_clr, crc_step, crc_shift, crc_msb;

  assign mask = lane_mask(width_q);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    tcnt_d    = tcnt_q;
    width_d   = width_q;
    word_d    = word_q;
    acc_d     = acc_q;
    data_d    = data_q;
    crcerr_d  = crcerr_q;
    frmerr_d  = frmerr_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    enter_ws  = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d  = StWaitStart;
          enter_ws = 1'b1;
        end
      end
      StWaitStart: begin
        if (!i_en) begin
          state_d = StIdle;
        end else if (!i_dat[0]) begin
          // Start bit beats a simultaneous timeout terminal count.
          state_d = StData;
          bcnt_d  = edges_per_word(width_q);
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (&tcnt_d) begin
            timeout_d = 1'b1;
            state_d   = StHalt;
          end
        end
      end
      StData: begin
        if (!i_en) begin
          state_d = StIdle;
        end else begin
          word_d = shift_word(word_q, width_q, i_dat);
          if (bcnt_q == 6'd1) begin
            valid_d = 1'b1;
            data_d  = word_d;
            last_d  = (wcnt_q == 10'd1);
            wcnt_d  = wcnt_q - 10'd1;
            if (wcnt_q == 10'd1) begin
              state_d = StCrc;
              bcnt_d  = 6'(CRC_LEN);
            end else begin
              bcnt_d = edges_per_word(width_q);
            end
          end else begin
            bcnt_d = bcnt_q - 6'd1;
          end
        end
      end
      StCrc: begin
        if (!i_en) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_q | ((i_dat ^ crc_msb) & mask);
          if (bcnt_q == 6'd1) state_d = StStop;
          else                bcnt_d  = bcnt_q - 6'd1;
        end
      end
      StStop: begin
        if (!i_en) begin
          state_d = StIdle;
        end else begin
          done_d   = 1'b1;
          crcerr_d = acc_q;
          frmerr_d = |(~i_dat & mask);
          state_d  = StWaitStart;
          enter_ws = 1'b1;
        end
      end
      StHalt: begin
        if (!i_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Per-block re-initialisation; width is captured here too so a mid-block
    // width change cannot desynchronise the edge counter from the lane mask.
    if (enter_ws) begin
      wcnt_d  = 10'(i_len >> 2);
      tcnt_d  = '0;
      width_d = i_width;
      acc_d   = '0;
    end
    // Status is held across back-to-back blocks and dropped only on a fresh arm.
    if (enter_ws && state_q == StIdle) begin
      crcerr_d = '0;
      frmerr_d = 1'b0;
    end

    busy_d = (state_d != StIdle) && (state_d != StHalt);
  end

  assign crc_clr   = {8{enter_ws}} | ~mask;
  assign crc_step  = (state_q == StData && i_en) ? mask : 8'h00;
  assign crc_shift = (state_q == StCrc && i_en) ? mask : 8'h00;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    sdrx_crc16 u_crc (
      .sd_clk  (sd_clk),
      .rst_n   (rst_n),
      .i_clr   (crc_clr[k]),
      .i_step  (crc_step[k]),
      .i_shift (crc_shift[k]),
      .i_bit   (i_dat[k]),
      .o_msb   (crc_msb[k])
    );
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
      width_q   <= W1;
      word_q    <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      crcerr_q  <= '0;
      frmerr_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      tcnt_q    <= tcnt_d;
      width_q   <= width_d;
      word_q    <= word_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      done_q    <= done_d;
      crcerr_q  <= crcerr_d;
      frmerr_q  <= frmerr_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;
  assign o_done    = done_q;
  assign o_crcerr  = crcerr_q;
  assign o_frmerr  = frmerr_q;
  assign o_timeout = timeout_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_sdrx_frame.sv
`timescale 1ns/1ps
module tb_sdrx_frame;
  import sdrx_pkg::*;

  logic        sd_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        i_en   = 1'b0;
  logic [1:0]  i_width = W1;
  logic [11:0] i_len   = 12'd4;
  logic [7:0]  i_dat   = 8'hFF;
  logic        o_valid, o_last, o_done, o_frmerr, o_timeout, o_busy;
  logic [31:0] o_data;
  logic [7:0]  o_crcerr;

  int checks = 0;
  int errors = 0;

  sdrx_frame #(.LGTIMEOUT(4)) dut (
    .sd_clk    (sd_clk),
    .rst_n     (rst_n),
    .i_en      (i_en),
    .i_width   (i_width),
    .i_len     (i_len),
    .i_dat     (i_dat),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_done    (o_done),
    .o_crcerr  (o_crcerr),
    .o_frmerr  (o_frmerr),
    .o_timeout (o_timeout),
    .o_busy    (o_busy)
  );

  always #5 sd_clk = ~sd_clk;

  // Output collector, sampled 1ns after each rising edge.
  logic [31:0] rx_words[$];
  logic        rx_lasts[$];
  int          done_cnt = 0;
  int          to_cnt = 0;
  int          stray_last = 0;
  logic [7:0]  cap_crcerr = '0;
  logic        cap_frmerr = 1'b0;

  always @(posedge sd_clk) begin
    #1;
    if (o_valid) begin
      rx_words.push_back(o_data);
      rx_lasts.push_back(o_last);
    end
    if (o_last && !o_valid) stray_last++;
    if (o_done) begin
      done_cnt++;
      cap_crcerr = o_crcerr;
      cap_frmerr = o_frmerr;
    end
    if (o_timeout) to_cnt++;
  end

  // Transmit-side model state.
  logic [31:0] tx_words[$];
  logic [15:0] crc_xor[8];
  logic        use_fixed = 1'b0;
  logic [15:0] fixed_crc = '0;
  logic [7:0]  stop_val = 8'hFF;
  bit          lane_bits[8][4096];

  // Drive on the falling edge; return 2ns after the rising edge that samples it.
  task automatic tick(input logic [7:0] d);
    @(negedge sd_clk);
    i_dat = d;
    @(posedge sd_clk);
    #2;
  endtask

  // Reference CRC16/0x1021 by long division of the message augmented with 16 zeros.
  function automatic logic [15:0] crc_ref(input int lane, input int n);
    logic [15:0] r;
    logic        top, b;
    r = '0;
    for (int i = 0; i < n + 16; i++) begin
      b   = (i < n) ? lane_bits[lane][i] : 1'b0;
      top = r[15];
      r   = {r[14:0], b};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic clear_rx;
    rx_words.delete();
    rx_lasts.delete();
    done_cnt = 0;
    to_cnt   = 0;
  endtask

  task automatic arm(input logic [1:0] w, input logic [11:0] len);
    i_en    = 1'b1;
    i_width = w;
    i_len   = len;
    tick(8'hFF);
  endtask

  task automatic disarm;
    i_en = 1'b0;
    tick(8'hFF);
    tick(8'hFF);
  endtask

  // Start bit, tx_words on `lanes` lanes, per-lane CRC, stop bits.
  task automatic send_block(input int lanes);
    int          epw, nb;
    logic [7:0]  d, chunk;
    logic [15:0] crc[8];
    epw = 32 / lanes;
    nb  = 0;
    tick(8'h00);
    foreach (tx_words[w]) begin
      for (int e = 0; e < epw; e++) begin
        chunk = 8'((tx_words[w] >> (32 - lanes * (e + 1))) & ((32'd1 << lanes) - 1));
        d = 8'hFF;
        for (int k = 0; k < lanes; k++) begin
          d[k] = chunk[k];
          lane_bits[k][nb] = chunk[k];
        end
        nb++;
        tick(d);
      end
    end
    for (int k = 0; k < 8; k++) crc[k] = '0;
    for (int k = 0; k < lanes; k++) crc[k] = use_fixed ? fixed_crc : (crc_ref(k, nb) ^ crc_xor[k]);
    for (int i = 0; i < 16; i++) begin
      d = 8'hFF;
      for (int k = 0; k < lanes; k++) d[k] = crc[k][15 - i];
      tick(d);
    end
    tick(stop_val);
  endtask

  task automatic reset_tx;
    tx_words.delete();
    for (int k = 0; k < 8; k++) crc_xor[k] = '0;
    use_fixed = 1'b0;
    stop_val  = 8'hFF;
  endtask

  task automatic test_reset;
    tick(8'hFF);
    checks++;
    if ({o_valid, o_data, o_last, o_done, o_crcerr, o_frmerr, o_timeout, o_busy} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {o_valid, o_data, o_last, o_done, o_crcerr, o_frmerr, o_timeout, o_busy});
    end
    @(negedge sd_clk);
    rst_n = 1'b1;
    tick(8'hFF);
    tick(8'hFF);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b required 0", o_busy);
    end
  endtask

  task automatic test_one_lane_ff;
    int bad, nlast;
    reset_tx();
    clear_rx();
    for (int i = 0; i < 128; i++) tx_words.push_back(32'hFFFF_FFFF);
    use_fixed = 1'b1;
    fixed_crc = 16'h7FA1;
    arm(W1, 12'd512);
    send_block(1);
    bad = 0;
    nlast = 0;
    foreach (rx_words[i]) if (rx_words[i] !== 32'hFFFF_FFFF) bad++;
    foreach (rx_lasts[i]) if (rx_lasts[i]) nlast++;
    checks++;
    if (rx_words.size() !== 128) begin
      errors++;
      $display("FAIL w1_count: got %0d required 128", rx_words.size());
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL w1_data: got %0d bad words required 0", bad);
    end
    checks++;
    if (nlast !== 1 || rx_lasts.size() != 128 || rx_lasts[127] !== 1'b1) begin
      errors++;
      $display("FAIL w1_last: got %0d last flags required 1 on word 128", nlast);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL w1_done: got %0d required 1", done_cnt);
    end
    checks++;
    if ({cap_crcerr, cap_frmerr} !== 9'd0) begin
      errors++;
      $display("FAIL w1_status: got crcerr %h frmerr %b required 00 0", cap_crcerr, cap_frmerr);
    end
    disarm();
  endtask

  task automatic test_four_lane;
    reset_tx();
    clear_rx();
    tx_words.push_back(32'h0123_4567);
    tx_words.push_back(32'h89AB_CDEF);
    arm(W4, 12'd8);
    send_block(4);
    checks++;
    if (rx_words.size() !== 2 || rx_words[0] !== 32'h0123_4567 || rx_words[1] !== 32'h89AB_CDEF)
    begin
      errors++;
      $display("FAIL w4_data: got %0d words first %h required 01234567 89abcdef",
               rx_words.size(), (rx_words.size() > 0) ? rx_words[0] : 32'hx);
    end
    checks++;
    if (rx_lasts.size() !== 2 || rx_lasts[0] !== 1'b0 || rx_lasts[1] !== 1'b1) begin
      errors++;
      $display("FAIL w4_last: got %0d flags required 0,1", rx_lasts.size());
    end
    checks++;
    if (done_cnt !== 1 || cap_crcerr !== 8'h00) begin
      errors++;
      $display("FAIL w4_crc: got done %0d crcerr %h required 1 00", done_cnt, cap_crcerr);
    end
    disarm();
  endtask

  task automatic test_crc_err;
    reset_tx();
    clear_rx();
    tx_words.push_back(32'hDEAD_BEEF);
    crc_xor[2] = 16'h0020;
    arm(W8, 12'd4);
    send_block(8);
    checks++;
    if (rx_words.size() !== 1 || rx_words[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL w8_data: got %0d words required 1 of deadbeef", rx_words.size());
    end
    checks++;
    if (cap_crcerr !== 8'h04) begin
      errors++;
      $display("FAIL w8_crcerr: got %h required 04", cap_crcerr);
    end
    checks++;
    if (done_cnt !== 1 || cap_frmerr !== 1'b0) begin
      errors++;
      $display("FAIL w8_frm_ok: got done %0d frmerr %b required 1 0", done_cnt, cap_frmerr);
    end
    disarm();
  endtask

  task automatic test_stop_err;
    reset_tx();
    clear_rx();
    tx_words.push_back(32'hDEAD_BEEF);
    stop_val = 8'hBF;
    arm(W8, 12'd4);
    send_block(8);
    checks++;
    if (done_cnt !== 1 || cap_frmerr !== 1'b1) begin
      errors++;
      $display("FAIL stop_frmerr: got done %0d frmerr %b required 1 1", done_cnt, cap_frmerr);
    end
    checks++;
    if (cap_crcerr !== 8'h00) begin
      errors++;
      $display("FAIL stop_crcerr: got %h required 00", cap_crcerr);
    end
    disarm();
  endtask

  task automatic test_async_reset;
    arm(W8, 12'd4);
    tick(8'h00);
    tick(8'hDE);
    @(negedge sd_clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_data, o_last, o_done, o_crcerr, o_frmerr, o_timeout, o_busy} !== 46'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0",
               {o_valid, o_data, o_last, o_done, o_crcerr, o_frmerr, o_timeout, o_busy});
    end
    i_en = 1'b0;
    @(negedge sd_clk);
    rst_n = 1'b1;
    tick(8'hFF);
  endtask

  task automatic test_timeout;
    int early;
    clear_rx();
    early = 0;
    arm(W1, 12'd4);
    tick(8'hFF);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy: got %b required 1", o_busy);
    end
    if (o_timeout) early++;
    for (int i = 2; i <= 14; i++) begin
      tick(8'hFF);
      if (o_timeout) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d pulses before cycle 15 required 0", early);
    end
    tick(8'hFF);
    checks++;
    if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got timeout %b busy %b required 1 0", o_timeout, o_busy);
    end
    for (int i = 0; i < 5; i++) tick(8'hFF);
    checks++;
    if (to_cnt !== 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: got pulses %0d busy %b required 1 0", to_cnt, o_busy);
    end
    disarm();
    arm(W1, 12'd4);
    tick(8'hFF);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_exit: got busy %b required 1", o_busy);
    end
    disarm();
  endtask

  task automatic test_back_to_back;
    logic [31:0] ab [3];
    ab[0] = 32'hA5C3_0F01;
    ab[1] = 32'h1234_5678;
    ab[2] = 32'hFFFF_0000;
    reset_tx();
    clear_rx();
    arm(W1, 12'd12);
    tick(8'h00);
    for (int w = 0; w < 2; w++)
      for (int b = 31; b >= 0; b--) tick({7'h7F, ab[w][b]});
    for (int b = 31; b >= 22; b--) tick({7'h7F, ab[2][b]});
    checks++;
    if (rx_words.size() !== 2 || rx_words[0] !== ab[0] || rx_words[1] !== ab[1]) begin
      errors++;
      $display("FAIL abort_pre_words: got %0d words required 2", rx_words.size());
    end
    clear_rx();
    i_en = 1'b0;
    for (int i = 0; i < 40; i++) tick((i % 2 == 0) ? 8'h00 : 8'hFF);
    checks++;
    if (rx_words.size() !== 0 || done_cnt !== 0 || to_cnt !== 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got words %0d done %0d timeout %0d busy %b required 0 0 0 0",
               rx_words.size(), done_cnt, to_cnt, o_busy);
    end
    arm(W1, 12'd4);
    tx_words.push_back(32'hC0FF_EE11);
    send_block(1);
    tx_words.delete();
    tx_words.push_back(32'h5A5A_A5A5);
    send_block(1);
    checks++;
    if (done_cnt !== 2 || cap_crcerr !== 8'h00 || cap_frmerr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got done %0d crcerr %h frmerr %b required 2 00 0",
               done_cnt, cap_crcerr, cap_frmerr);
    end
    checks++;
    if (rx_words.size() !== 2 || rx_words[0] !== 32'hC0FF_EE11 || rx_words[1] !== 32'h5A5A_A5A5)
    begin
      errors++;
      $display("FAIL b2b_data: got %0d words required c0ffee11 5a5aa5a5", rx_words.size());
    end
    checks++;
    if (rx_lasts.size() !== 2 || rx_lasts[0] !== 1'b1 || rx_lasts[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last: got %0d flags required 1,1", rx_lasts.size());
    end
    disarm();
    checks++;
    if (stray_last !== 0) begin
      errors++;
      $display("FAIL last_without_valid: got %0d required 0", stray_last);
    end
  endtask

  initial begin
    test_reset();
    test_one_lane_ff();
    test_four_lane();
    test_crc_err();
    test_stop_err();
    test_async_reset();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
